// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int         BCD_DIGIT_W    = 4;
  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Handshake bundle for bin_to_bcd_seq; the ovf line exists only when BIN2BCD_OVF_EN is defined.
interface bin_to_bcd_seq_if #(
  parameter int WIDTH  = 10,
  parameter int DIGITS = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      in_bin;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   out_bcd;
  logic                  busy;
`ifdef BIN2BCD_OVF_EN
  logic                  ovf;

  modport master (
    output in_valid, in_bin, out_ready,
    input  in_ready, out_valid, out_bcd, busy, ovf
  );
  modport slave (
    input  in_valid, in_bin, out_ready,
    output in_ready, out_valid, out_bcd, busy, ovf
  );
`else
  modport master (
    output in_valid, in_bin, out_ready,
    input  in_ready, out_valid, out_bcd, busy
  );
  modport slave (
    input  in_valid, in_bin, out_ready,
    output in_ready, out_valid, out_bcd, busy
  );
`endif
endinterface

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] din,
  output logic [BCD_DIGIT_W-1:0] dout
);

  assign dout = (din >= BCD_ADJ_THRESH) ? din + BCD_ADJ_ADD : din;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one bit per cycle.
// Optional overflow flag enabled by defining BIN2BCD_OVF_EN.
//
// state | meaning
// IDLE  | ready to accept a new binary word
// SHIFT | adjust digits then shift one bit, WIDTH cycles
// DONE  | result presented until out_ready
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 10,
  parameter int DIGITS = 4
) (
  input logic             clk,
  input logic             rst_n,
  bin_to_bcd_seq_if.slave bus
);

  localparam int                BCD_W    = BCD_DIGIT_W * DIGITS;
  localparam int                CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   bin_q, bin_d;
  logic [BCD_W-1:0]   scratch_q, scratch_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BCD_W-1:0]   out_bcd_q, out_bcd_d;
  logic [BCD_W-1:0]   adj;
  logic [BCD_W:0]     shifted;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (scratch_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .dout (adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Top bit is the carry out of the most significant digit.
  assign shifted = {adj, bin_q[WIDTH-1]};

`ifdef BIN2BCD_OVF_EN
  logic ovf_q, ovf_d;
  always_comb begin
    ovf_d = ovf_q;
    if (state_q == IDLE && bus.in_valid) ovf_d = 1'b0;
    else if (state_q == SHIFT)           ovf_d = ovf_q | shifted[BCD_W];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end
  assign bus.ovf = ovf_q;
`else
  logic carry_unused;
  assign carry_unused = shifted[BCD_W];
`endif

  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    out_bcd_d = out_bcd_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          bin_d     = bus.in_bin;
          scratch_d = '0;
          cnt_d     = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        bin_d     = bin_q << 1;
        scratch_d = shifted[BCD_W-1:0];
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          out_bcd_d = shifted[BCD_W-1:0];
          state_d   = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bin_q     <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      out_bcd_q <= '0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      out_bcd_q <= out_bcd_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q == SHIFT);
  assign bus.out_bcd   = out_bcd_q;

endmodule
